// File: rtl/vm1801_bus_pkg.sv
// Shared definitions for the vm1801mini bus slaves.
//   bus_state_e : bridge FSM states
//   WIN_BITS    : log2 of the decoded window size in bytes (2 KB)
//   SEL_*       : RAM byte-lane select encodings (bit 0 = low byte)
package vm1801_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StRdWait,
    StRdAck,
    StWr,
    StWrAck
  } bus_state_e;

  localparam int unsigned WIN_BITS = 11;

  localparam logic [1:0] SEL_LO   = 2'b01;
  localparam logic [1:0] SEL_HI   = 2'b10;
  localparam logic [1:0] SEL_WORD = 2'b11;

endpackage

// File: rtl/bus_win_decode.sv
// Combinational window decoder: compares the address tag (bits above the
// window) with the tag of the BASE parameter.
//   tag_i : AD[15:WIN_BITS] from the address phase
//   hit_o : 1 when the address falls inside the window
module bus_win_decode
  import vm1801_bus_pkg::*;
#(
  parameter logic [15:0] BASE = 16'o000000
) (
  input  logic [15-WIN_BITS:0] tag_i,
  output logic                 hit_o
);

  assign hit_o = (tag_i == BASE[15:WIN_BITS]);

endmodule

// File: rtl/qbus_ram_bridge.sv
// Bus-slave bridge between the multiplexed processor bus and a 1Kx16
// synchronous block RAM. Runs the SYNC/DIN/DOUT/RPLY handshake and turns
// each data phase into one RAM read or one byte-masked RAM write.
//   CLK, RST_N          : clock, async active-low reset
//   AD_IN               : address (address phase) / write data (data phase)
//   SYNC, DIN, DOUT     : bus cycle, read request, write data valid
//   WTBT                : byte write qualifier for DOUT
//   AD_OUT, AD_OE       : registered read data and its drive enable
//   RPLY, HIT           : slave reply, latched window match
//   RAM_ADDR/SEL/DI/WR  : RAM word address, byte lanes, write data, strobe
//   RAM_DO              : RAM read data (one clock after the address)
module qbus_ram_bridge
  import vm1801_bus_pkg::*;
#(
  parameter logic [15:0] BASE = 16'o000000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] AD_IN,
  input  logic        SYNC,
  input  logic        DIN,
  input  logic        DOUT,
  input  logic        WTBT,
  output logic [15:0] AD_OUT,
  output logic        AD_OE,
  output logic        RPLY,
  output logic        HIT,
  output logic [9:0]  RAM_ADDR,
  output logic [1:0]  RAM_SEL,
  output logic [15:0] RAM_DI,
  output logic        RAM_WR,
  input  logic [15:0] RAM_DO
);

  bus_state_e  state_q, state_d;
  logic        armed_q, armed_d;
  logic        a0_q, a0_d;
  logic [15:0] ad_out_q, ad_out_d;
  logic        ad_oe_q, ad_oe_d;
  logic        rply_q, rply_d;
  logic        hit_q, hit_d;
  logic [9:0]  ram_addr_q, ram_addr_d;
  logic [1:0]  ram_sel_q, ram_sel_d;
  logic [15:0] ram_di_q, ram_di_d;
  logic        ram_wr_q, ram_wr_d;

  logic win_hit;

  bus_win_decode #(
    .BASE (BASE)
  ) u_win_decode (
    .tag_i (AD_IN[15:WIN_BITS]),
    .hit_o (win_hit)
  );

  always_comb begin
    state_d    = state_q;
    // A new cycle may only start once SYNC has been seen low since reset,
    // so a SYNC still asserted across reset release is ignored.
    armed_d    = armed_q | ~SYNC;
    a0_d       = a0_q;
    ad_out_d   = ad_out_q;
    ad_oe_d    = ad_oe_q;
    rply_d     = rply_q;
    hit_d      = hit_q;
    ram_addr_d = ram_addr_q;
    ram_sel_d  = ram_sel_q;
    ram_di_d   = ram_di_q;
    ram_wr_d   = ram_wr_q;

    if (state_q != StIdle && !SYNC) begin
      // Bus cycle ended or aborted; a write already strobed stays done.
      state_d   = StIdle;
      rply_d    = 1'b0;
      ad_oe_d   = 1'b0;
      hit_d     = 1'b0;
      ram_wr_d  = 1'b0;
      ram_sel_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (SYNC && armed_q) begin
            a0_d       = AD_IN[0];
            ram_addr_d = AD_IN[WIN_BITS-1:1];
            hit_d      = win_hit;
            state_d    = StAddr;
          end
        end
        StAddr: begin
          // On a miss stay here silently; the master times out.
          if (hit_q) begin
            if (DIN) begin
              state_d = StRdWait;
            end else if (DOUT) begin
              ram_di_d  = AD_IN;
              ram_sel_d = WTBT ? (a0_q ? SEL_HI : SEL_LO) : SEL_WORD;
              ram_wr_d  = 1'b1;
              state_d   = StWr;
            end
          end
        end
        StRdWait: begin
          ad_out_d = RAM_DO;
          ad_oe_d  = 1'b1;
          rply_d   = 1'b1;
          state_d  = StRdAck;
        end
        StRdAck: begin
          // Back to StAddr rather than idle so a DATIO write can follow.
          if (!DIN) begin
            rply_d  = 1'b0;
            ad_oe_d = 1'b0;
            state_d = StAddr;
          end
        end
        StWr: begin
          ram_wr_d = 1'b0;
          rply_d   = 1'b1;
          state_d  = StWrAck;
        end
        StWrAck: begin
          if (!DOUT) begin
            rply_d    = 1'b0;
            ram_sel_d = '0;
            state_d   = StAddr;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      armed_q    <= 1'b0;
      a0_q       <= 1'b0;
      ad_out_q   <= '0;
      ad_oe_q    <= 1'b0;
      rply_q     <= 1'b0;
      hit_q      <= 1'b0;
      ram_addr_q <= '0;
      ram_sel_q  <= '0;
      ram_di_q   <= '0;
      ram_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      a0_q       <= a0_d;
      ad_out_q   <= ad_out_d;
      ad_oe_q    <= ad_oe_d;
      rply_q     <= rply_d;
      hit_q      <= hit_d;
      ram_addr_q <= ram_addr_d;
      ram_sel_q  <= ram_sel_d;
      ram_di_q   <= ram_di_d;
      ram_wr_q   <= ram_wr_d;
    end
  end

  assign AD_OUT   = ad_out_q;
  assign AD_OE    = ad_oe_q;
  assign RPLY     = rply_q;
  assign HIT      = hit_q;
  assign RAM_ADDR = ram_addr_q;
  assign RAM_SEL  = ram_sel_q;
  assign RAM_DI   = ram_di_q;
  assign RAM_WR   = ram_wr_q;

endmodule

// File: tb/tb_qbus_ram_bridge.sv
// Directed bench for qbus_ram_bridge: a table of single-cycle vectors for
// plain read/write cycles, then hand-written miss, DATIO, abort and reset
// sequences. A behavioural 1Kx16 RAM sits behind the main instance.
module tb_qbus_ram_bridge;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [15:0] AD_IN = '0;
  logic        SYNC = 1'b0, DIN = 1'b0, DOUT = 1'b0, WTBT = 1'b0;

  logic [15:0] AD_OUT, RAM_DI, RAM_DO;
  logic        AD_OE, RPLY, HIT, RAM_WR;
  logic [9:0]  RAM_ADDR;
  logic [1:0]  RAM_SEL;

  logic [15:0] m_ad_out, m_ram_di;
  logic        m_ad_oe, m_rply, m_hit, m_ram_wr;
  logic [9:0]  m_ram_addr;
  logic [1:0]  m_ram_sel;
  logic [15:0] m_ram_do = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  qbus_ram_bridge #(.BASE(16'o000000)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .AD_IN(AD_IN), .SYNC(SYNC), .DIN(DIN), .DOUT(DOUT),
    .WTBT(WTBT), .AD_OUT(AD_OUT), .AD_OE(AD_OE), .RPLY(RPLY), .HIT(HIT),
    .RAM_ADDR(RAM_ADDR), .RAM_SEL(RAM_SEL), .RAM_DI(RAM_DI), .RAM_WR(RAM_WR),
    .RAM_DO(RAM_DO)
  );

  qbus_ram_bridge #(.BASE(16'o004000)) u_dut_miss (
    .CLK(CLK), .RST_N(RST_N), .AD_IN(AD_IN), .SYNC(SYNC), .DIN(DIN), .DOUT(DOUT),
    .WTBT(WTBT), .AD_OUT(m_ad_out), .AD_OE(m_ad_oe), .RPLY(m_rply), .HIT(m_hit),
    .RAM_ADDR(m_ram_addr), .RAM_SEL(m_ram_sel), .RAM_DI(m_ram_di), .RAM_WR(m_ram_wr),
    .RAM_DO(m_ram_do)
  );

  // Behavioural RAM: synchronous read, byte-masked write.
  logic [15:0] mem [1024];
  always @(posedge CLK) begin
    if (RAM_WR) begin
      if (RAM_SEL[0]) mem[RAM_ADDR][7:0]  <= RAM_DI[7:0];
      if (RAM_SEL[1]) mem[RAM_ADDR][15:8] <= RAM_DI[15:8];
    end
    RAM_DO <= mem[RAM_ADDR];
  end

  int   wr_pulses = 0;
  int   rply_rises = 0;
  logic rply_prev = 1'b0;
  always @(posedge CLK) begin
    if (RAM_WR) wr_pulses <= wr_pulses + 1;
    if (RPLY && !rply_prev) rply_rises <= rply_rises + 1;
    rply_prev <= RPLY;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_read(input logic [15:0] a, output logic [15:0] d);
    bit got;
    got = 1'b0;
    SYNC = 1'b1; AD_IN = a; DIN = 1'b0; DOUT = 1'b0;
    tick();
    DIN = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (RPLY) got = 1'b1;
    end
    d = AD_OUT;
    chk("read_reply_seen", 32'(got), 32'd1);
    DIN = 1'b0;
    tick();
    SYNC = 1'b0;
    tick();
  endtask

  typedef struct {
    string       nm;
    logic        sync, din, dout, wtbt;
    logic [15:0] ad;
    logic        rply, oe, hit, wr;
    logic [1:0]  sel;
    logic [9:0]  addr;
    logic        chk_ad;
    logic [15:0] adout;
  } vec_t;

  function automatic vec_t mk(string nm, logic s, logic di, logic dO, logic wt,
                              logic [15:0] ad, logic rp, logic oe, logic h, logic w,
                              logic [1:0] sel, logic [9:0] addr, logic ca,
                              logic [15:0] ado);
    vec_t v;
    v.nm = nm; v.sync = s; v.din = di; v.dout = dO; v.wtbt = wt; v.ad = ad;
    v.rply = rp; v.oe = oe; v.hit = h; v.wr = w; v.sel = sel; v.addr = addr;
    v.chk_ad = ca; v.adout = ado;
    return v;
  endfunction

  vec_t vecs[16];

  initial begin
    logic [15:0] rd;
    int w0, r0;

    foreach (mem[i]) mem[i] = 16'h0000;
    mem[0]    = 16'h15C0;
    mem[1]    = 16'h1234;
    mem[5]    = 16'h8000;
    mem[1023] = 16'hBEEF;

    //             name        S  DI DO WT AD        RP OE H  W  SEL    ADDR CA ADOUT
    vecs[0]  = mk("rd_addr",   1, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 2'b00, 0, 0, 16'h0000);
    vecs[1]  = mk("rd_din",    1, 1, 0, 0, 16'h0000, 0, 0, 1, 0, 2'b00, 0, 0, 16'h0000);
    vecs[2]  = mk("rd_rply",   1, 1, 0, 0, 16'h0000, 1, 1, 1, 0, 2'b00, 0, 1, 16'h15C0);
    vecs[3]  = mk("rd_hold",   1, 1, 0, 0, 16'h0000, 1, 1, 1, 0, 2'b00, 0, 1, 16'h15C0);
    vecs[4]  = mk("rd_drop",   1, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 2'b00, 0, 0, 16'h0000);
    vecs[5]  = mk("rd_end",    0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 2'b00, 0, 0, 16'h0000);
    vecs[6]  = mk("bw_addr",   1, 0, 0, 0, 16'o000003, 0, 0, 1, 0, 2'b00, 1, 0, 16'h0000);
    vecs[7]  = mk("bw_strobe", 1, 0, 1, 1, 16'hAB00, 0, 0, 1, 1, 2'b10, 1, 0, 16'h0000);
    vecs[8]  = mk("bw_rply",   1, 0, 1, 1, 16'hAB00, 1, 0, 1, 0, 2'b10, 1, 0, 16'h0000);
    vecs[9]  = mk("bw_drop",   1, 0, 0, 0, 16'hAB00, 0, 0, 1, 0, 2'b00, 1, 0, 16'h0000);
    vecs[10] = mk("bw_end",    0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 2'b00, 1, 0, 16'h0000);
    vecs[11] = mk("rb_addr",   1, 0, 0, 0, 16'o000002, 0, 0, 1, 0, 2'b00, 1, 0, 16'h0000);
    vecs[12] = mk("rb_din",    1, 1, 0, 0, 16'o000002, 0, 0, 1, 0, 2'b00, 1, 0, 16'h0000);
    vecs[13] = mk("rb_rply",   1, 1, 0, 0, 16'o000002, 1, 1, 1, 0, 2'b00, 1, 1, 16'hAB34);
    vecs[14] = mk("rb_drop",   1, 0, 0, 0, 16'o000002, 0, 0, 1, 0, 2'b00, 1, 0, 16'h0000);
    vecs[15] = mk("rb_end",    0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 2'b00, 1, 0, 16'h0000);

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ad_out", 32'(AD_OUT), 32'h0);
    chk("rst_ad_oe", 32'(AD_OE), 32'h0);
    chk("rst_rply", 32'(RPLY), 32'h0);
    chk("rst_hit", 32'(HIT), 32'h0);
    chk("rst_ram_addr", 32'(RAM_ADDR), 32'h0);
    chk("rst_ram_sel", 32'(RAM_SEL), 32'h0);
    chk("rst_ram_di", 32'(RAM_DI), 32'h0);
    chk("rst_ram_wr", 32'(RAM_WR), 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    tick();

    // Word read, high-lane byte write, readback
    for (int i = 0; i < 16; i++) begin
      SYNC = vecs[i].sync; DIN = vecs[i].din; DOUT = vecs[i].dout;
      WTBT = vecs[i].wtbt; AD_IN = vecs[i].ad;
      tick();
      chk({vecs[i].nm, ".rply"}, 32'(RPLY), 32'(vecs[i].rply));
      chk({vecs[i].nm, ".oe"}, 32'(AD_OE), 32'(vecs[i].oe));
      chk({vecs[i].nm, ".hit"}, 32'(HIT), 32'(vecs[i].hit));
      chk({vecs[i].nm, ".wr"}, 32'(RAM_WR), 32'(vecs[i].wr));
      chk({vecs[i].nm, ".sel"}, 32'(RAM_SEL), 32'(vecs[i].sel));
      chk({vecs[i].nm, ".addr"}, 32'(RAM_ADDR), 32'(vecs[i].addr));
      if (vecs[i].chk_ad) chk({vecs[i].nm, ".ad_out"}, 32'(AD_OUT), 32'(vecs[i].adout));
    end
    WTBT = 1'b0;
    chk("bw_mem_word1", 32'(mem[1]), 32'hAB34);

    // Miss on the BASE=004000 instance, DIN held 20 cycles
    begin
      logic any_rply, any_oe, any_wr, any_hit;
      any_rply = 0; any_oe = 0; any_wr = 0; any_hit = 0;
      SYNC = 1'b1; AD_IN = 16'o000000;
      tick();
      chk("miss_main_hit", 32'(HIT), 32'h1);
      DIN = 1'b1;
      for (int i = 0; i < 20; i++) begin
        tick();
        any_rply |= m_rply; any_oe |= m_ad_oe; any_wr |= m_ram_wr; any_hit |= m_hit;
      end
      chk("miss_hit", 32'(any_hit), 32'h0);
      chk("miss_rply", 32'(any_rply), 32'h0);
      chk("miss_ad_oe", 32'(any_oe), 32'h0);
      chk("miss_ram_wr", 32'(any_wr), 32'h0);
      DIN = 1'b0; SYNC = 1'b0;
      tick();
      // Out-of-window address on the main instance
      SYNC = 1'b1; AD_IN = 16'o004000;
      tick();
      chk("miss2_hit", 32'(HIT), 32'h0);
      DIN = 1'b1;
      any_rply = 0;
      for (int i = 0; i < 5; i++) begin
        tick();
        any_rply |= RPLY;
      end
      chk("miss2_rply", 32'(any_rply), 32'h0);
      DIN = 1'b0; SYNC = 1'b0;
      tick();
    end

    // DATIO on word 5: read then write in one SYNC
    w0 = wr_pulses; r0 = rply_rises;
    SYNC = 1'b1; AD_IN = 16'o000012;
    tick();
    DIN = 1'b1;
    tick();
    tick();
    chk("datio_rd_rply", 32'(RPLY), 32'h1);
    chk("datio_rd_data", 32'(AD_OUT), 32'h8000);
    DIN = 1'b0;
    tick();
    chk("datio_rd_drop", 32'(RPLY), 32'h0);
    DOUT = 1'b1; WTBT = 1'b0; AD_IN = 16'h8001;
    tick();
    chk("datio_wr", 32'(RAM_WR), 32'h1);
    chk("datio_sel", 32'(RAM_SEL), 32'(2'b11));
    chk("datio_di", 32'(RAM_DI), 32'h8001);
    tick();
    chk("datio_wr_rply", 32'(RPLY), 32'h1);
    chk("datio_wr_off", 32'(RAM_WR), 32'h0);
    DOUT = 1'b0;
    tick();
    chk("datio_wr_drop", 32'(RPLY), 32'h0);
    SYNC = 1'b0;
    tick();
    tick();
    chk("datio_wr_pulses", 32'(wr_pulses - w0), 32'd1);
    chk("datio_rply_pulses", 32'(rply_rises - r0), 32'd2);
    do_read(16'o000012, rd);
    chk("datio_readback", 32'(rd), 32'h8001);

    // Abort during RD_WAIT, then a normal read of word 1023
    SYNC = 1'b1; AD_IN = 16'o003776;
    tick();
    DIN = 1'b1;
    tick();
    SYNC = 1'b0; DIN = 1'b0;
    tick();
    chk("abort_rply", 32'(RPLY), 32'h0);
    chk("abort_oe", 32'(AD_OE), 32'h0);
    chk("abort_hit", 32'(HIT), 32'h0);
    tick();
    chk("abort_rply_late", 32'(RPLY), 32'h0);
    do_read(16'o003776, rd);
    chk("top_word_data", 32'(rd), 32'hBEEF);
    chk("top_word_addr", 32'(RAM_ADDR), 32'd1023);

    // Reset asserted in WR_ACK, SYNC held high through release
    SYNC = 1'b1; AD_IN = 16'o000024;
    tick();
    DOUT = 1'b1; AD_IN = 16'h5555;
    tick();
    tick();
    chk("rstw_rply_before", 32'(RPLY), 32'h1);
    #2 RST_N = 1'b0;
    #1;
    chk("rstw_rply", 32'(RPLY), 32'h0);
    chk("rstw_ad_oe", 32'(AD_OE), 32'h0);
    chk("rstw_hit", 32'(HIT), 32'h0);
    chk("rstw_ram_addr", 32'(RAM_ADDR), 32'h0);
    chk("rstw_ram_sel", 32'(RAM_SEL), 32'h0);
    chk("rstw_ram_di", 32'(RAM_DI), 32'h0);
    chk("rstw_ram_wr", 32'(RAM_WR), 32'h0);
    DOUT = 1'b0; AD_IN = 16'o000026;
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstw_no_start_hit", 32'(HIT), 32'h0);
      chk("rstw_no_start_addr", 32'(RAM_ADDR), 32'h0);
    end
    SYNC = 1'b0;
    tick();
    SYNC = 1'b1;
    tick();
    chk("rstw_restart_hit", 32'(HIT), 32'h1);
    chk("rstw_restart_addr", 32'(RAM_ADDR), 32'd11);
    SYNC = 1'b0;
    tick();
    do_read(16'o000024, rd);
    chk("rstw_committed", 32'(rd), 32'h5555);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qbus_ram_bridge.md
# qbus_ram_bridge

Bus-slave front end for the on-chip 1K×16 block RAM in the vm1801mini system. Decodes a parameterised 2 KB window on the processor's multiplexed address/data bus, runs the SYNC/DIN/DOUT/RPLY handshake, and turns each bus cycle into a single synchronous RAM read or byte-masked write. It sits directly upstream of the RAM and owns its address, byte-select, write-data and write-strobe inputs.

## Interface
Parameters:
- BASE, 16'o000000: window base byte address; only bits [15:11] are significant.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST_N  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- AD_IN  in  16  bus address (address phase) or write data (data phase).
- SYNC  in  1  bus cycle active; the address is valid on its first sampled-high edge.
- DIN  in  1  read data request.
- DOUT  in  1  write data valid.
- WTBT  in  1  byte write, sampled together with DOUT.
- AD_OUT  out  16  read data, registered.
- AD_OE  out  1  AD_OUT drive enable.
- RPLY  out  1  slave reply.
- HIT  out  1  latched window match for the current cycle.
- RAM_ADDR  out  10  RAM word address (latched A[10:1]).
- RAM_SEL  out  2  byte lanes (bit 0 = low byte).
- RAM_DI  out  16  RAM write data.
- RAM_WR  out  1  RAM write strobe, one cycle.
- RAM_DO  in  16  RAM read data, valid one clock after the address edge.

## Operation
States:
- IDLE
- ADDR
- RD_WAIT
- RD_ACK
- WR
- WR_ACK

Transitions and actions:
- IDLE, SYNC=1:
  - Latch A0 and RAM_ADDR ← AD_IN[10:1].
  - HIT ← (AD_IN[15:11] == BASE[15:11]).
  - Go to ADDR.
- ADDR, HIT=0: ignore DIN/DOUT and never assert RPLY, so the cycle times out elsewhere.
- ADDR, HIT=1, DIN=1: go to RD_WAIT. DIN has priority if DIN and DOUT are both high.
- ADDR, HIT=1, DOUT=1:
  - RAM_DI ← AD_IN.
  - RAM_SEL ← WTBT ? (A0 ? 2'b10 : 2'b01) : 2'b11.
  - RAM_WR ← 1.
  - Go to WR.
- RD_WAIT: AD_OUT ← RAM_DO, AD_OE ← 1, RPLY ← 1, go to RD_ACK.
- RD_ACK, DIN=0: RPLY ← 0, AD_OE ← 0, return to ADDR. This allows a read-modify-write (DATIO) cycle within one SYNC.
- WR: RAM_WR ← 0, RPLY ← 1, go to WR_ACK.
- WR_ACK, DOUT=0: RPLY ← 0, RAM_SEL ← 0, return to ADDR.
- Any non-IDLE state, SYNC=0:
  - Go to IDLE.
  - Clear RPLY, AD_OE, HIT, RAM_WR and RAM_SEL.
  - Abandon any pending read.
  - A write already strobed stays committed.

Boundary rules:
- Window address A[10:1] = 1023 is valid. There is no wrap past the window.
- AD_IN is not re-latched until the next IDLE→ADDR transition.

## Timing
- Reset (asynchronous assert, synchronous release), all outputs:
  - AD_OUT = 0, AD_OE = 0, RPLY = 0, HIT = 0.
  - RAM_ADDR = 0, RAM_SEL = 0, RAM_DI = 0, RAM_WR = 0.
  - State = IDLE.
- Reset mid-cycle drops RPLY immediately. The FSM restarts only after SYNC has been seen low in IDLE; a SYNC still high at release is ignored.
- Read: with DIN sampled high at edge k, RPLY and AD_OE rise after edge k+1. RPLY falls one edge after DIN is sampled low.
- Write: with DOUT sampled high at edge k, RAM_WR is high for exactly the cycle after edge k. RPLY rises after edge k+1 and falls one edge after DOUT is sampled low.
- RAM_ADDR is stable from ADDR entry until IDLE, so RAM_DO is valid by RD_WAIT.
- All inputs are synchronous to CLK. The bus-side synchroniser is not part of this block.

## Structure
- Shared package `vm1801_bus_pkg` holds:
  - the state enum;
  - WIN_BITS = 11;
  - byte-lane constants SEL_LO, SEL_HI, SEL_WORD.
- Single sub-module `bus_win_decode`: a combinational BASE comparison producing the match used for HIT. Everything else stays in one FSM module.
- No other hierarchy.

## Test plan
- Word read: RAM preloaded with [0] = 16'h15C0, BASE = 0. SYNC with AD_IN = 0, then DIN → AD_OUT = 16'h15C0 and RPLY high two edges after DIN. Drop DIN → RPLY low next edge.
- Byte write high lane: address 16'o000003, DOUT with AD_IN = 16'hAB00 and WTBT = 1 → one-cycle RAM_WR, RAM_SEL = 2'b10, RAM_ADDR = 1. Readback gives word 1 = 16'hAB00 merged with the untouched low byte.
- Miss: BASE = 16'o004000, access 16'o000000 with DIN held for 20 cycles → HIT = 0, RPLY and AD_OE stay 0, RAM_WR stays 0.
- DATIO: one SYNC covering DIN, read 16'h8000, then DOUT with 16'h8001 → two RPLY pulses, one write. Later readback = 16'h8001.
- Abort: SYNC drops during RD_WAIT → no RPLY, AD_OE = 0, state IDLE. The next cycle to address 1023 completes normally.
- Reset mid-write: RST_N low in WR_ACK → all outputs 0 at once. With SYNC held high through release, no new cycle starts until SYNC is cycled low then high.
